// File: rtl/ila_trigger_capture_if.sv
// Readout stream from the trigger capture buffer.
// Master presents words; slave accepts with rd_ready.
interface ila_trigger_capture_if #(
  parameter int SAMPLE_WIDTH = 25,
  parameter int DEPTH_LOG2   = 6
);
  logic                    rd_valid;
  logic                    rd_ready;
  logic [SAMPLE_WIDTH-1:0] rd_data;
  logic [DEPTH_LOG2-1:0]   rd_index;
  logic                    rd_last;

  modport master (
    output rd_valid,
    output rd_data,
    output rd_index,
    output rd_last,
    input  rd_ready
  );

  modport slave (
    input  rd_valid,
    input  rd_data,
    input  rd_index,
    input  rd_last,
    output rd_ready
  );
endinterface

// File: rtl/ila_trigger_capture.sv
// Circular capture buffer with masked-equality trigger.
// Freezes a pre/post window and replays it oldest-first.
module ila_trigger_capture #(
  parameter int SAMPLE_WIDTH = 25,
  parameter int DEPTH_LOG2   = 6,
  parameter int PRETRIG      = 16
) (
  input  logic                    clk,
  input  logic                    ILA_rst,
  input  logic [SAMPLE_WIDTH-1:0] ila_sample_dut,
  input  logic                    arm,
  input  logic [SAMPLE_WIDTH-1:0] trig_value,
  input  logic [SAMPLE_WIDTH-1:0] trig_mask,
  output logic                    armed,
  output logic                    triggered,
  ila_trigger_capture_if.master   rd
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PRE_P =
    DEPTH_LOG2'(PRETRIG);
  localparam logic [DEPTH_LOG2:0] POST_N =
    (DEPTH_LOG2+1)'(DEPTH - PRETRIG);
  localparam logic [DEPTH_LOG2-1:0] LAST_I =
    DEPTH_LOG2'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    WAIT_TRIG,
    POST,
    READ
  } state_t;

  state_t state;
  state_t nxt;

  logic [SAMPLE_WIDTH-1:0] mem [DEPTH];
  logic [SAMPLE_WIDTH-1:0] ram_q;
  logic [DEPTH_LOG2-1:0]   wr_ptr;
  logic [DEPTH_LOG2-1:0]   trig_ptr;
  logic [DEPTH_LOG2-1:0]   pre_cnt;
  logic [DEPTH_LOG2-1:0]   idx;
  logic [DEPTH_LOG2-1:0]   idx_nxt;
  logic [DEPTH_LOG2-1:0]   raddr;
  logic [DEPTH_LOG2:0]     post_cnt;
  logic                    we;
  logic                    match;
  logic                    hs;
  logic                    valid;

  assign match =
    ((ila_sample_dut ^ trig_value) & trig_mask) == '0;
  assign hs = valid && rd.rd_ready;

  always_ff @(posedge clk or posedge ILA_rst) begin
    if (ILA_rst) state <= IDLE;
    else         state <= nxt;
  end

  always_comb begin
    nxt = state;
    we  = 1'b0;
    case (state)
      IDLE: begin
        if (arm)
          nxt = (PRETRIG == 0) ? WAIT_TRIG : PRE;
      end
      PRE: begin
        we = 1'b1;
        if (pre_cnt == PRE_P - 1'b1) nxt = WAIT_TRIG;
      end
      WAIT_TRIG: begin
        we = 1'b1;
        if (match)
          nxt = (POST_N == 1) ? READ : POST;
      end
      POST: begin
        we = 1'b1;
        if (post_cnt == POST_N - 1'b1) nxt = READ;
      end
      READ: begin
        if (hs && idx == LAST_I) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge ILA_rst) begin
    if (ILA_rst) begin
      wr_ptr   <= '0;
      trig_ptr <= '0;
      pre_cnt  <= '0;
      post_cnt <= '0;
      idx      <= '0;
      valid    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arm) begin
            wr_ptr  <= '0;
            pre_cnt <= '0;
          end
        end
        PRE: begin
          wr_ptr  <= wr_ptr + 1'b1;
          pre_cnt <= pre_cnt + 1'b1;
        end
        WAIT_TRIG: begin
          wr_ptr <= wr_ptr + 1'b1;
          if (match) begin
            trig_ptr <= wr_ptr;
            post_cnt <= 1;
          end
        end
        POST: begin
          wr_ptr   <= wr_ptr + 1'b1;
          post_cnt <= post_cnt + 1'b1;
        end
        READ: begin
          if (!valid) begin
            valid <= 1'b1;
          end else if (hs) begin
            if (idx == LAST_I) begin
              valid <= 1'b0;
              idx   <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Address follows the post-handshake index, so a stall re-reads
  // the same word and the output holds without a separate register.
  assign idx_nxt = hs ? idx + 1'b1 : idx;
  assign raddr   = trig_ptr - PRE_P + idx_nxt;

  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr] <= ila_sample_dut;
    ram_q <= mem[raddr];
  end

  assign armed     = (state == PRE) || (state == WAIT_TRIG);
  assign triggered = (state == POST) || (state == READ);

  assign rd.rd_valid = valid;
  assign rd.rd_data  = valid ? ram_q : '0;
  assign rd.rd_index = idx;
  assign rd.rd_last  = valid && (idx == LAST_I);

endmodule

// File: tb/tb_ila_trigger_capture.sv
// Scoreboard bench for ila_trigger_capture: directed captures,
// backpressure, ignored arm, resets, and a PRETRIG=0 build.
module tb_ila_trigger_capture;
  localparam int W = 25;
  localparam int L = 6;
  localparam int D = 64;

  typedef struct packed {
    logic [W-1:0] d;
    logic [L-1:0] i;
    logic         l;
  } exp_t;

  logic         clk = 1'b0;
  logic         ILA_rst = 1'b1;
  logic [W-1:0] sample = '0;
  logic [W-1:0] trig_value = '0;
  logic [W-1:0] trig_mask = '0;
  logic         arm = 1'b0;
  logic         arm0 = 1'b0;
  logic         armed, triggered;
  logic         armed0, triggered0;

  ila_trigger_capture_if #(.SAMPLE_WIDTH(W), .DEPTH_LOG2(L)) rd ();
  ila_trigger_capture_if #(.SAMPLE_WIDTH(W), .DEPTH_LOG2(L)) rd0 ();

  ila_trigger_capture #(
    .SAMPLE_WIDTH(W), .DEPTH_LOG2(L), .PRETRIG(16)
  ) dut (
    .clk(clk), .ILA_rst(ILA_rst),
    .ila_sample_dut(sample), .arm(arm),
    .trig_value(trig_value), .trig_mask(trig_mask),
    .armed(armed), .triggered(triggered), .rd(rd)
  );

  ila_trigger_capture #(
    .SAMPLE_WIDTH(W), .DEPTH_LOG2(L), .PRETRIG(0)
  ) dut0 (
    .clk(clk), .ILA_rst(ILA_rst),
    .ila_sample_dut(sample), .arm(arm0),
    .trig_value(trig_value), .trig_mask(trig_mask),
    .armed(armed0), .triggered(triggered0), .rd(rd0)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  exp_t sb0[$];
  int vectors = 0;
  int miscompares = 0;
  int hs_cnt = 0;

  logic         pv = 1'b0;
  logic         pr = 1'b1;
  logic [W-1:0] pd = '0;
  logic [L-1:0] pi = '0;

  always @(negedge clk) begin
    exp_t e;
    if (!ILA_rst && rd.rd_valid) begin
      if (pv && !pr) begin
        vectors++;
        if (rd.rd_data !== pd || rd.rd_index !== pi) begin
          miscompares++;
          $display("FAIL hold: got data=%0d idx=%0d want data=%0d idx=%0d",
                   rd.rd_data, rd.rd_index, pd, pi);
        end
      end
      if (rd.rd_ready) begin
        vectors++;
        hs_cnt++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL extra word: got data=%0d idx=%0d want none",
                   rd.rd_data, rd.rd_index);
        end else begin
          e = sb.pop_front();
          if (rd.rd_data !== e.d || rd.rd_index !== e.i ||
              rd.rd_last !== e.l) begin
            miscompares++;
            $display("FAIL word: got d=%0d i=%0d l=%0b want d=%0d i=%0d l=%0b",
                     rd.rd_data, rd.rd_index, rd.rd_last, e.d, e.i, e.l);
          end
        end
      end
    end
    pv = rd.rd_valid && !ILA_rst;
    pr = rd.rd_ready;
    pd = rd.rd_data;
    pi = rd.rd_index;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!ILA_rst && rd0.rd_valid && rd0.rd_ready) begin
      vectors++;
      if (sb0.size() == 0) begin
        miscompares++;
        $display("FAIL p0 extra: got data=%0d want none", rd0.rd_data);
      end else begin
        e = sb0.pop_front();
        if (rd0.rd_data !== e.d || rd0.rd_index !== e.i ||
            rd0.rd_last !== e.l) begin
          miscompares++;
          $display("FAIL p0 word: got d=%0d i=%0d l=%0b want d=%0d i=%0d l=%0b",
                   rd0.rd_data, rd0.rd_index, rd0.rd_last, e.d, e.i, e.l);
        end
      end
    end
  end

  task automatic check_zero(input string nm);
    vectors++;
    if ({armed, triggered, rd.rd_valid, rd.rd_last,
         rd.rd_data, rd.rd_index, armed0, rd0.rd_valid} !== '0) begin
      miscompares++;
      $display("FAIL %s: got armed=%0b trig=%0b v=%0b d=%0d i=%0d want all 0",
               nm, armed, triggered, rd.rd_valid, rd.rd_data, rd.rd_index);
    end
  endtask

  task automatic do_reset();
    ILA_rst = 1'b1;
    arm = 1'b0;
    #1;
    check_zero("reset_mid");
    sb.delete();
    @(posedge clk);
    #1;
    ILA_rst = 1'b0;
  endtask

  task automatic capture(input logic [W-1:0] val, input logic [W-1:0] msk,
                         input int arm_at, input int first, input bit bp,
                         input bit extra_arm, input int rst_sample,
                         input int rst_hs);
    exp_t e;
    bit   done;
    trig_value = val;
    trig_mask  = msk;
    if (rst_sample < 0) begin
      for (int i = 0; i < D; i++) begin
        e.d = W'(first + i);
        e.i = L'(i);
        e.l = (i == D - 1);
        sb.push_back(e);
      end
    end
    hs_cnt = 0;
    @(posedge clk);
    #1;
    sample = '0;
    done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(posedge clk);
      #1;
      sample = sample + 1'b1;
      arm = (sample == W'(arm_at)) ||
            (extra_arm && (sample == 320 || sample == 360 ||
                           sample == 380));
      rd.rd_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if ((rst_sample >= 0 && sample == W'(rst_sample)) ||
          (rst_hs >= 0 && hs_cnt == rst_hs)) begin
        do_reset();
        done = 1'b1;
      end else if (sample > W'(arm_at + 2) && !armed && !triggered &&
                   sb.size() == 0) begin
        done = 1'b1;
      end
    end
    arm = 1'b0;
    rd.rd_ready = 1'b1;
    vectors++;
    if (!done || sb.size() != 0) begin
      miscompares++;
      $display("FAIL timeout: got %0d words left want 0", sb.size());
    end
    sb.delete();
    if (rst_sample < 0 && rst_hs < 0) begin
      vectors++;
      if (armed !== 1'b0 || triggered !== 1'b0 || rd.rd_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL end_idle: got armed=%0b trig=%0b v=%0b want 0 0 0",
                 armed, triggered, rd.rd_valid);
      end
    end
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic capture_p0();
    exp_t e;
    bit   done;
    trig_mask = '0;
    for (int i = 0; i < D; i++) begin
      e.d = W'(11 + i);
      e.i = L'(i);
      e.l = (i == D - 1);
      sb0.push_back(e);
    end
    @(posedge clk);
    #1;
    sample = '0;
    done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(posedge clk);
      #1;
      sample = sample + 1'b1;
      arm0 = (sample == 10);
      if (sample > 12 && !armed0 && !triggered0 && sb0.size() == 0)
        done = 1'b1;
    end
    arm0 = 1'b0;
    vectors++;
    if (!done || sb0.size() != 0) begin
      miscompares++;
      $display("FAIL p0 timeout: got %0d words left want 0", sb0.size());
    end
    sb0.delete();
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin
    rd.rd_ready  = 1'b1;
    rd0.rd_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_state");
    ILA_rst = 1'b0;
    capture(25'd100, '1, 10, 84, 1'b0, 1'b0, -1, -1);
    capture(25'h04, 25'h0F, 10, 20, 1'b0, 1'b0, -1, -1);
    capture(25'd0, 25'd0, 10, 11, 1'b0, 1'b0, -1, -1);
    capture_p0();
    capture(25'd100, '1, 10, 84, 1'b1, 1'b0, -1, -1);
    capture(25'd300, '1, 10, 284, 1'b0, 1'b1, -1, -1);
    repeat (20) @(posedge clk);
    #1;
    capture(25'd100, '1, 10, 0, 1'b0, 1'b0, 120, -1);
    capture(25'd100, '1, 10, 84, 1'b0, 1'b0, -1, -1);
    capture(25'd100, '1, 10, 84, 1'b0, 1'b0, -1, 5);
    capture(25'd100, '1, 10, 84, 1'b1, 1'b0, -1, -1);
    repeat (10) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ila_trigger_capture.md
Name: ila_trigger_capture

Overview:
- Downstream consumer of the DUT sample bus (`ila_sample_dut`, e.g. the 25-bit blink counter).
- Continuously records samples into a circular buffer once armed, detects a masked-equality trigger, and freezes a window of PRETRIG samples before the trigger and the trigger sample plus the samples after it.
- Replays the frozen window oldest-first over a valid/ready stream to the ILA readout logic.

Parameters:
- SAMPLE_WIDTH, 25: width of `ila_sample_dut` and of stored samples.
- DEPTH_LOG2, 6: log2 of buffer depth; DEPTH = 2**DEPTH_LOG2 (64).
- PRETRIG, 16: samples kept before the trigger sample. Legal range 0..DEPTH-1.

Ports:
- clk  in  1  sole clock, rising edge.
- ILA_rst  in  1  reset, asynchronous, active-high.
- ila_sample_dut  in  SAMPLE_WIDTH  DUT sample, captured every clk in capture states.
- arm  in  1  start capture; honoured only in IDLE.
- trig_value  in  SAMPLE_WIDTH  trigger compare value; must be static while armed.
- trig_mask  in  SAMPLE_WIDTH  1 = bit participates in the compare.
- armed  out  1  high in PRE and WAIT_TRIG.
- triggered  out  1  high in POST and READ.
- rd_valid  out  1  `rd_data` valid.
- rd_ready  in  1  consumer accepts the word when high together with `rd_valid`.
- rd_data  out  SAMPLE_WIDTH  captured sample.
- rd_index  out  DEPTH_LOG2  position in the window; 0 = oldest, PRETRIG = trigger sample.
- rd_last  out  1  high with the final word (`rd_index` = DEPTH-1).

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; all pointers and counters = 0.
  - armed, triggered, rd_valid, rd_last = 0; rd_data = 0; rd_index = 0.
  - Buffer contents are don't-care.
- Match condition: `match = ((ila_sample_dut ^ trig_value) & trig_mask) == 0`, evaluated on the current input. trig_mask = 0 means always match.
- States:
  - IDLE: `arm`=1 at an edge -> PRE; `wr_ptr` and `pre_cnt` cleared.
  - PRE: each edge writes `ila_sample_dut` to buf[wr_ptr]; wr_ptr++ (wraps mod DEPTH); pre_cnt++. `match` is ignored. After PRETRIG writes -> WAIT_TRIG. If PRETRIG=0, go straight to WAIT_TRIG.
  - WAIT_TRIG: each edge writes and increments `wr_ptr`; wrap overwrites the oldest data.
    - On a write where `match`=1: trig_ptr = wr_ptr (address of the trigger sample), post_cnt = 1, -> POST.
    - If DEPTH-PRETRIG = 1, go to READ instead.
  - POST: each edge writes and increments `wr_ptr`, post_cnt++. When DEPTH-PRETRIG samples (trigger included) have been written -> READ. `ila_sample_dut` is then ignored until the next arm.
  - READ: words are streamed for index i = 0..DEPTH-1 from buf[(trig_ptr - PRETRIG + i) mod DEPTH].
    - First `rd_valid` no later than 2 cycles after entering READ.
    - `rd_data`, `rd_index` and `rd_last` are held stable while `rd_valid` && !`rd_ready`.
    - On a handshake the next word is presented either the next cycle or after one bubble cycle; back-to-back is preferred.
    - After the handshake with `rd_last` -> IDLE; `rd_valid` drops the following cycle.
- `arm` outside IDLE is ignored, including during READ. Only one arm pulse is needed; a held `arm` re-arms in the IDLE cycle after READ completes.
- A trigger match in PRE is never recorded. A match in POST has no effect.
- `ILA_rst` mid-capture or mid-readout: immediate IDLE, outputs at reset values, no partial stream continues.
- Buffer is a synchronous-read RAM inferable as block RAM. Writes occur only in PRE, WAIT_TRIG and POST.

Test Plan:
- Basic capture (defaults; stimulus: free-running counter; mask=all ones; value=100; `arm` sampled when counter=10): PRE stores 11..26, trigger at 100. With `rd_ready`=1, the stream is 84..147, `rd_index` 16 = 100, `rd_last` with 147, then IDLE, `armed`=`triggered`=0.
- Pre-trigger masking (mask=0x0F, value=0x04, arm at counter=10): match at 20 during PRE is ignored, trigger at 36 (0x24). Stream is 20..83, index 16 = 36.
- Immediate trigger (mask=0, arm at counter=10): trigger at 27, stream 11..74. Also check the PRETRIG=0 build: trigger on the first sample after arm, index 0 = that sample.
- Backpressure: toggle `rd_ready` pseudo-randomly (~50%). Words and order are identical to the first scenario; `rd_data`/`rd_index` never change while `rd_valid` && !`rd_ready`; exactly 64 handshakes.
- Ignored arm and wrap: pulse `arm` during POST and READ; no restart, single 64-word stream. Trigger at counter 300 with arm at 10 (`wr_ptr` has wrapped several times): stream is 284..347.
- Reset mid-operation: assert `ILA_rst` during POST, and separately after 5 read handshakes. All outputs return to 0 the same cycle. After release, a new arm yields a correct full window.
